// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher and the pulse generator blocks.
package pulse_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_STRETCH = 1'b1
    } state_e;

    localparam int unsigned PULSE_GEN_CNT_WIDTH = 4;
    localparam int unsigned PULSE_GEN_LEN_MIN   = 1;

endpackage : pulse_pkg

// File: rtl/pulse_stretch_cnt.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module pulse_stretch_cnt #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 zero_q, zero_d;

    // Load has priority; decrement stops at zero so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule : pulse_stretch_cnt

// File: rtl/pulse_stretch.sv
// Stretches each accepted trigger into a level of max(LEN,1) cycles.
// Define PULSE_STRETCH_RETRIG_EN to let a mid-stretch pulse extend the level instead of flagging overrun.
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PULSE_GEN_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 PULSE_SIG,
    input  logic [CNT_WIDTH-1:0] LEN,
    input  logic                 OVR_CLR,
    output logic                 LVL_SIG,
    output logic                 OVR_FLAG
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_m1;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic                 ovr_set;
    logic                 ovr_q, ovr_d;

    // LEN of zero is treated as a one-cycle stretch.
    always_comb begin
        len_m1 = (LEN == '0) ? '0 : (LEN - CNT_WIDTH'(1));
    end

    pulse_stretch_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (cnt_load),
        .load_val_i (len_m1),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (PULSE_SIG) begin
                    state_d = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (cnt_zero && !PULSE_SIG) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter control and overrun detection; a pulse on the last cycle reloads seamlessly.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        ovr_set  = 1'b0;
        LVL_SIG  = (state_q == ST_STRETCH);
        case (state_q)
            ST_IDLE: begin
                cnt_load = PULSE_SIG;
            end
            ST_STRETCH: begin
                if (cnt_zero) begin
                    cnt_load = PULSE_SIG;
                end else if (PULSE_SIG) begin
`ifdef PULSE_STRETCH_RETRIG_EN
                    cnt_load = 1'b1;
`else
                    cnt_dec  = 1'b1;
                    ovr_set  = 1'b1;
`endif
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_comb begin
        ovr_d = ovr_set | (ovr_q & ~OVR_CLR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign OVR_FLAG = ovr_q;

endmodule : pulse_stretch

// File: tb/tb_pulse_stretch.sv
// Directed self-checking bench for pulse_stretch; expectations follow PULSE_STRETCH_RETRIG_EN.
module tb_pulse_stretch;

    localparam int unsigned CW = 4;
`ifdef PULSE_STRETCH_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic          PULSE_SIG;
    logic [CW-1:0] LEN;
    logic          OVR_CLR;
    logic          LVL_SIG;
    logic          OVR_FLAG;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_stretch #(
        .CNT_WIDTH (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PULSE_SIG (PULSE_SIG),
        .LEN       (LEN),
        .OVR_CLR   (OVR_CLR),
        .LVL_SIG   (LVL_SIG),
        .OVR_FLAG  (OVR_FLAG)
    );

    // Rising edges at 10, 20, 30 ...; inputs change and outputs are sampled on falling edges.
    initial begin
        CLK = 1'b1;
        forever begin
            #5 CLK = 1'b0;
            #5 CLK = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit i of pulses/clrs is applied to rising edge i; bit i of trace is LVL_SIG after that edge.
    task automatic run_seq(input logic [CW-1:0] len, input logic [15:0] pulses,
                           input logic [15:0] clrs, output logic [15:0] trace);
        LEN   = len;
        trace = '0;
        for (int i = 0; i < 16; i++) begin
            PULSE_SIG = pulses[i];
            OVR_CLR   = clrs[i];
            @(negedge CLK);
            trace[i] = LVL_SIG;
        end
        PULSE_SIG = 1'b0;
        OVR_CLR   = 1'b0;
    endtask

    task automatic run_test(input string tag, input logic [CW-1:0] len, input logic [15:0] pulses,
                            input logic [15:0] clrs, input logic [15:0] exp_trace, input logic exp_ovr);
        logic [15:0] trace;
        run_seq(len, pulses, clrs, trace);
        check({tag, "_lvl"}, 32'(trace), 32'(exp_trace));
        check({tag, "_ovr"}, 32'(OVR_FLAG), 32'(exp_ovr));
    endtask

    initial begin
        RST       = 1'b0;
        PULSE_SIG = 1'b0;
        OVR_CLR   = 1'b0;
        LEN       = CW'(3);
        #3;
        check("rst_lvl", 32'(LVL_SIG), 32'd0);
        check("rst_ovr", 32'(OVR_FLAG), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        run_test("single_len3",  CW'(3),  16'h0001, 16'h0000, 16'h0007, 1'b0);
        run_test("single_len0",  CW'(0),  16'h0001, 16'h0000, 16'h0001, 1'b0);
        run_test("single_len1",  CW'(1),  16'h0001, 16'h0000, 16'h0001, 1'b0);
        run_test("single_len15", CW'(15), 16'h0001, 16'h0000, 16'h7FFF, 1'b0);
        run_test("back2back",    CW'(3),  16'h0009, 16'h0000, 16'h003F, 1'b0);
        run_test("overlap",      CW'(3),  16'h0003, 16'h0000,
                 RETRIG ? 16'h000F : 16'h0007, ~RETRIG);
        run_test("clr_vs_set",   CW'(3),  16'h0003, 16'h0002,
                 RETRIG ? 16'h000F : 16'h0007, ~RETRIG);
        run_test("ovr_clear",    CW'(3),  16'h0000, 16'h0001, 16'h0000, 1'b0);
        run_test("held_len2",    CW'(2),  16'h00FF, 16'h0000,
                 RETRIG ? 16'h01FF : 16'h00FF, ~RETRIG);

        // Asynchronous reset in the middle of a stretch, then a pulse on the first edge after release.
        LEN       = CW'(3);
        PULSE_SIG = 1'b1;
        @(negedge CLK);
        PULSE_SIG = 1'b0;
        check("pre_rst_lvl", 32'(LVL_SIG), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("async_rst_lvl", 32'(LVL_SIG), 32'd0);
        check("async_rst_ovr", 32'(OVR_FLAG), 32'd0);
        @(negedge CLK);
        check("hold_rst_lvl", 32'(LVL_SIG), 32'd0);
        RST = 1'b1;
        run_test("post_rst", CW'(3), 16'h0001, 16'h0000, 16'h0007, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pulse_stretch
